// File: rtl/regfile_wb.sv
// Thirty-two-entry MIPS register file at the end of the write-back path, with last-write debug capture.
// Optional same-cycle WB->ID bypass is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wregin,
    input  logic [4:0]  RdRtin,
    input  logic [31:0] writedata,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [4:0]  lastwn,
    output logic [31:0] lastwd,
    output logic [15:0] wcount
);

    // Entry 0 exists only to keep indexing simple; it is never written and never read.
    logic [31:0] regs [0:31];
    logic        commit;

    assign commit = wregin && (RdRtin != 5'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            lastwn <= '0;
            lastwd <= '0;
            wcount <= '0;
        end else if (commit) begin
            regs[RdRtin] <= writedata;
            lastwn       <= RdRtin;
            lastwd       <= writedata;
            wcount       <= wcount + 16'd1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight WB value so ID sees it in the same cycle; commit already excludes r0.
    always_comb begin
        qa = '0;
        qb = '0;
        if (rna != 5'd0) begin
            qa = (commit && (rna == RdRtin)) ? writedata : regs[rna];
        end
        if (rnb != 5'd0) begin
            qb = (commit && (rnb == RdRtin)) ? writedata : regs[rnb];
        end
    end
`else
    always_comb begin
        qa = '0;
        qb = '0;
        if (rna != 5'd0) begin
            qa = regs[rna];
        end
        if (rnb != 5'd0) begin
            qb = regs[rnb];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, commit, r0 protection, same-cycle hazard, sweep, counter wrap.
module tb_regfile_wb;

    logic        clk;
    logic        clrn;
    logic        wregin;
    logic [4:0]  RdRtin;
    logic [31:0] writedata;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [4:0]  lastwn;
    logic [31:0] lastwd;
    logic [15:0] wcount;

    int checks   = 0;
    int failures = 0;

    regfile_wb dut (
        .clk       (clk),
        .clrn      (clrn),
        .wregin    (wregin),
        .RdRtin    (RdRtin),
        .writedata (writedata),
        .rna       (rna),
        .rnb       (rnb),
        .qa        (qa),
        .qb        (qb),
        .lastwn    (lastwn),
        .lastwd    (lastwd),
        .wcount    (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Commit one write on the next rising edge, then return 2 time units past it with wregin low.
    task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
        wregin    = 1'b1;
        RdRtin    = rd;
        writedata = data;
        @(posedge clk);
        #2;
        wregin = 1'b0;
    endtask

    task automatic read_ports(input logic [4:0] a, input logic [4:0] b);
        rna = a;
        rnb = b;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        clrn = 1'b0;
        @(posedge clk);
        #2;
        clrn = 1'b1;
    endtask

    logic [31:0] exp_hazard;
    logic [4:0]  pair_b;

    initial begin
        clrn      = 1'b0;
        wregin    = 1'b0;
        RdRtin    = '0;
        writedata = '0;
        rna       = '0;
        rnb       = '0;

        // Reset state
        #3;
        read_ports(5'd5, 5'd31);
        check("reset_qa", qa, 32'h0);
        check("reset_qb", qb, 32'h0);
        check("reset_wcount", {16'h0, wcount}, 32'h0);
        check("reset_lastwn", {27'h0, lastwn}, 32'h0);
        check("reset_lastwd", lastwd, 32'h0);
        @(posedge clk);
        #2;
        clrn = 1'b1;

        // Write r5, then asynchronous reset clears it before any edge
        write_reg(5'd5, 32'hDEADBEEF);
        read_ports(5'd5, 5'd0);
        check("pre_reset_r5", qa, 32'hDEADBEEF);
        check("pre_reset_wcount", {16'h0, wcount}, 32'h1);
        clrn = 1'b0;
        #1;
        check("async_reset_r5", qa, 32'h0);
        check("async_reset_wcount", {16'h0, wcount}, 32'h0);
        check("async_reset_lastwn", {27'h0, lastwn}, 32'h0);
        check("async_reset_lastwd", lastwd, 32'h0);

        // Writes ignored while clrn held low
        write_reg(5'd6, 32'h0BAD0BAD);
        read_ports(5'd6, 5'd6);
        check("held_reset_r6", qa, 32'h0);
        check("held_reset_wcount", {16'h0, wcount}, 32'h0);
        clrn = 1'b1;

        // Basic write/read; first edge after release is honored
        write_reg(5'd7, 32'h12345678);
        read_ports(5'd7, 5'd7);
        check("basic_qa", qa, 32'h12345678);
        check("basic_qb", qb, 32'h12345678);
        check("basic_lastwn", {27'h0, lastwn}, 32'd7);
        check("basic_lastwd", lastwd, 32'h12345678);
        check("basic_wcount", {16'h0, wcount}, 32'd1);

        // r0 protection
        write_reg(5'd0, 32'hFFFFFFFF);
        read_ports(5'd0, 5'd7);
        check("r0_qa", qa, 32'h0);
        check("r0_qb_r7", qb, 32'h12345678);
        check("r0_wcount", {16'h0, wcount}, 32'd1);
        check("r0_lastwn", {27'h0, lastwn}, 32'd7);
        check("r0_lastwd", lastwd, 32'h12345678);

        // wregin=0 never changes state
        wregin    = 1'b0;
        RdRtin    = 5'd3;
        writedata = 32'hAAAA5555;
        @(posedge clk);
        #2;
        read_ports(5'd3, 5'd3);
        check("nowe_r3", qa, 32'h0);
        check("nowe_wcount", {16'h0, wcount}, 32'd1);

        // Same-cycle hazard on r9
        write_reg(5'd9, 32'h1);
        wregin    = 1'b1;
        RdRtin    = 5'd9;
        writedata = 32'h2;
        read_ports(5'd9, 5'd9);
`ifdef REGFILE_WB_BYPASS_EN
        exp_hazard = 32'h2;
`else
        exp_hazard = 32'h1;
`endif
        check("hazard_qa_before", qa, exp_hazard);
        check("hazard_qb_before", qb, exp_hazard);
        read_ports(5'd0, 5'd7);
        check("hazard_r0_no_bypass", qa, 32'h0);
        check("hazard_other_reg", qb, 32'h12345678);
        read_ports(5'd9, 5'd9);
        @(posedge clk);
        #2;
        wregin = 1'b0;
        #1;
        check("hazard_qa_after", qa, 32'h2);
        check("hazard_qb_after", qb, 32'h2);
        check("hazard_wcount", {16'h0, wcount}, 32'd3);

        // Reset asserted mid-cycle while a write is pending: write lost
        wregin    = 1'b1;
        RdRtin    = 5'd10;
        writedata = 32'h00000055;
        #2;
        clrn = 1'b0;
        @(posedge clk);
        #2;
        wregin = 1'b0;
        read_ports(5'd10, 5'd9);
        check("midcycle_reset_r10", qa, 32'h0);
        check("midcycle_reset_r9", qb, 32'h0);
        clrn = 1'b1;

        // Full sweep from a clean reset
        do_reset();
        for (int n = 1; n < 32; n++) begin
            write_reg(n[4:0], 32'h100 + n);
        end
        check("sweep_wcount", {16'h0, wcount}, 32'd31);
        check("sweep_lastwn", {27'h0, lastwn}, 32'd31);
        check("sweep_lastwd", lastwd, 32'h11F);
        for (int n = 0; n < 32; n++) begin
            pair_b = 5'(n * 7 + 3);
            read_ports(n[4:0], pair_b);
            check($sformatf("sweep_qa_r%0d", n), qa, (n == 0) ? 32'h0 : 32'h100 + n);
            check($sformatf("sweep_qb_r%0d", pair_b), qb,
                  (pair_b == 5'd0) ? 32'h0 : 32'h100 + {27'h0, pair_b});
        end

        // Counter wrap: 65536 writes to r1 return wcount to zero
        do_reset();
        read_ports(5'd1, 5'd2);
        wregin = 1'b1;
        RdRtin = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            writedata = i;
            @(posedge clk);
            #2;
            if (i == 65534) begin
                check("wrap_wcount_ffff", {16'h0, wcount}, 32'h0000FFFF);
            end
        end
        wregin = 1'b0;
        #1;
        check("wrap_wcount_zero", {16'h0, wcount}, 32'h0);
        check("wrap_r1", qa, 32'h0000FFFF);
        check("wrap_r2", qb, 32'h0);
        check("wrap_lastwd", lastwd, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
